rca_pipe: RTL and testbench
===========================

Name: rca_pipe

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor for the booth_mul datapath.
- Splits an N-bit carry chain into STAGES segments, one register boundary per segment, so wide partial-product accumulation closes timing at high clock rates.
- Adds an add/subtract mode, signed-overflow flag and valid/ready flow control. The plain combinational adder has none of these.
- Sits between the Booth partial-product generator and the accumulator register.

Parameters:
- N, 16, operand/result width; N >= 2.
- STAGES, 4, pipeline depth and number of carry segments; 1 <= STAGES <= N and N % STAGES == 0 (elaboration-time assertion).
- SEG, N/STAGES, derived segment width; not user-overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- A  input  N  operand A.
- B  input  N  operand B.
- Carry_i  input  1  carry-in; ignored when Sub_i=1.
- Sub_i  input  1  0: S=A+B+Carry_i; 1: S=A+~B+1 (A-B).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- S  output  N  sum/difference.
- Carry_o  output  1  raw carry out of bit N-1. In subtract mode 1 = no borrow.
- Ovf_o  output  1  two's-complement overflow: carry into bit N-1 XOR Carry_o.

Behaviour:
- Reset (async assert, sync deassert at the source): every stage valid bit=0, every data/carry register=0. Outputs: out_valid=0, S=0, Carry_o=0, Ovf_o=0, in_ready=1.
- Global advance: adv = out_ready | ~out_valid; in_ready = adv (combinational).
- When adv=1, every stage register loads from its predecessor. When adv=0, every stage holds.
- Bubbles are not squeezed: an empty stage still waits for adv.
- Input capture: a beat is accepted when in_valid & in_ready.
- Stage 0 sums segment 0 (bits SEG-1:0) of A and B_eff with c_in.
  - B_eff = Sub_i ? ~B : B.
  - c_in = Sub_i ? 1 : Carry_i.
- Stage 0 registers: sum segment 0, segment carry, and the unconsumed upper A/B_eff segments.
- Stage k (1..STAGES-1) sums segment k using the registered carry from stage k-1. It forwards lower sum segments unchanged and upper operand segments skewed.
- The last stage also registers carry-into-MSB for the Ovf_o computation.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1 with no stall. Throughput: 1 beat/cycle.
- out_valid is the valid bit of the last stage.
- S, Carry_o and Ovf_o are held stable while out_valid=1 and out_ready=0 (AXI-style; no change until handshake).
- Ovf_o is only meaningful when out_valid=1.
- Widths: no sign extension; arithmetic is modulo 2^N plus Carry_o.
- STAGES=1 degenerates to a single registered adder with the same handshake.
- Simultaneous out handshake and input accept in the same cycle: legal, no bubble inserted.
- Reset mid-operation: in-flight beats are discarded with no partial output; out_valid drops asynchronously.
- in_valid=0 with adv=1 inserts a bubble; data registers may take don't-care values but valid=0.

Decomposition:
- arith_pkg: localparam helpers (segment-width function), plus typedef for the per-stage record {valid, sum_lo, a_hi, b_hi, carry, cmsb}. The record is defined with parameter-free max widths or as a struct inside the module generate.
- Sub-module rca_seg #(W): combinational W-bit ripple adder built from full-adder cells (a, b, Ci, s, Co per bit). Outputs sum, carry out and carry into MSB. One instance per stage.

Test Plan (N=16, STAGES=4):
- Add wrap: A=0xFFFF, B=0x0001, Carry_i=0, Sub_i=0, out_ready=1 -> exactly 4 cycles later S=0x0000, Carry_o=1, Ovf_o=0.
- Subtract: A=0x0005, B=0x0007, Sub_i=1 -> S=0xFFFE, Carry_o=0, Ovf_o=0. A=0x0005, B=0x0005 -> S=0x0000, Carry_o=1.
- Overflow: A=0x7FFF, B=0x0001 add -> S=0x8000, Ovf_o=1. A=0x8000, B=0x0001, Sub_i=1 -> S=0x7FFF, Ovf_o=1.
- Streaming plus backpressure:
  - Stimulus: 8 back-to-back beats, A=i, B=0x0100*i; out_ready held 0 for 3 cycles starting when the first out_valid rises.
  - Required: in_ready=0 during the stall; S stable during the stall; all 8 results emitted in order with none lost or duplicated.
- Reset mid-flight: accept 3 beats, assert rst on the 2nd cycle after the first accept -> out_valid=0, S=0 immediately; after release, the first new beat appears after exactly 4 cycles.
- Carry_i ignore and random: Sub_i=1, Carry_i=1, A=0x1234, B=0x0234 -> S=0x1000, Carry_o=1. Then 10k random beats with random out_ready, checked against a reference model {Carry_o,S} = A + B_eff + c_in.

Source files
------------

// File: rtl/rca_pipe_pkg.sv
// rtl/rca_pipe_pkg.sv - shared types and helpers for the pipelined ripple-carry adder/subtractor
package rca_pipe_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int seg_width(int n, int stages);
    return (stages > 0) ? n / stages : n;
  endfunction

  // Signed overflow: carry into the MSB disagrees with carry out of it.
  function automatic logic ovf_flag(logic c_msb, logic c_out);
    return c_msb ^ c_out;
  endfunction

endpackage

// File: rtl/rca_pipe_if.sv
// rtl/rca_pipe_if.sv - operand/result handshake bundle for rca_pipe
interface rca_pipe_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Carry_i;
  logic         Sub_i;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] S;
  logic         Carry_o;
  logic         Ovf_o;

  modport master (
    output in_valid, A, B, Carry_i, Sub_i, out_ready,
    input  in_ready, out_valid, S, Carry_o, Ovf_o
  );

  modport slave (
    input  in_valid, A, B, Carry_i, Sub_i, out_ready,
    output in_ready, out_valid, S, Carry_o, Ovf_o
  );
endinterface

// File: rtl/rca_seg.sv
// rtl/rca_seg.sv - combinational W-bit ripple segment built from full-adder cells
module rca_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         cmsb
);
  logic [W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co   = c[W];
  assign cmsb = c[W-1];
endmodule

// File: rtl/rca_pipe.sv
// rtl/rca_pipe.sv - pipelined ripple-carry adder/subtractor, one carry segment per stage
module rca_pipe
  import rca_pipe_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input logic       clk,
  input logic       rst,
  rca_pipe_if.slave bus
);
  localparam int SEG = seg_width(N, STAGES);

  typedef struct packed {
    logic         valid;
    logic [N-1:0] sum_lo;
    logic [N-1:0] a_hi;
    logic [N-1:0] b_hi;
    logic         carry;
    logic         cmsb;
  } stage_t;

  if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_param_check
    $error("rca_pipe: N must be >= 2 and divisible by STAGES (1..N)");
  end

  stage_t       st_r   [STAGES];
  stage_t       st_nxt [STAGES];
  logic         adv;
  op_e          op;
  logic [N-1:0] b_eff;
  logic         c_in;

  assign op    = op_e'(bus.Sub_i);
  assign b_eff = (op == OP_SUB) ? ~bus.B : bus.B;
  assign c_in  = (op == OP_SUB) ? 1'b1 : bus.Carry_i;

  // Whole pipeline moves in lockstep; bubbles are not squeezed out.
  assign adv          = bus.out_ready | ~st_r[STAGES-1].valid;
  assign bus.in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic           prev_valid;
    logic [N-1:0]   prev_sum;
    logic [N-1:0]   prev_a;
    logic [N-1:0]   prev_b;
    logic           prev_c;
    logic [SEG-1:0] seg_s;
    logic           seg_co;
    logic           seg_cmsb;
    stage_t         nxt;

    if (k == 0) begin : g_head
      assign prev_valid = bus.in_valid;
      assign prev_sum   = '0;
      assign prev_a     = bus.A;
      assign prev_b     = b_eff;
      assign prev_c     = c_in;
    end else begin : g_tail
      assign prev_valid = st_r[k-1].valid;
      assign prev_sum   = st_r[k-1].sum_lo;
      assign prev_a     = st_r[k-1].a_hi;
      assign prev_b     = st_r[k-1].b_hi;
      assign prev_c     = st_r[k-1].carry;
    end

    rca_seg #(.W(SEG)) u_seg (
      .a    (prev_a[k*SEG +: SEG]),
      .b    (prev_b[k*SEG +: SEG]),
      .ci   (prev_c),
      .s    (seg_s),
      .co   (seg_co),
      .cmsb (seg_cmsb)
    );

    always_comb begin
      nxt                     = '0;
      nxt.valid               = prev_valid;
      nxt.sum_lo              = prev_sum;
      nxt.sum_lo[k*SEG +: SEG] = seg_s;
      nxt.a_hi                = prev_a;
      nxt.b_hi                = prev_b;
      nxt.carry               = seg_co;
      nxt.cmsb                = seg_cmsb;
    end

    assign st_nxt[k] = nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        st_r[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        st_r[k] <= st_nxt[k];
      end
    end
  end

  assign bus.out_valid = st_r[STAGES-1].valid;
  assign bus.S         = st_r[STAGES-1].sum_lo;
  assign bus.Carry_o   = st_r[STAGES-1].carry;
  assign bus.Ovf_o     = ovf_flag(st_r[STAGES-1].cmsb, st_r[STAGES-1].carry);
endmodule

// File: tb/tb_rca_pipe.sv
// tb/tb_rca_pipe.sv - scoreboard bench for rca_pipe (N=16, STAGES=4)
module tb_rca_pipe;
  localparam int N      = 16;
  localparam int STAGES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   fails  = 0;
  int   rx_cnt = 0;
  logic [N+1:0] exp_q [$];

  rca_pipe_if #(.N(N)) bus ();

  rca_pipe #(.N(N), .STAGES(STAGES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: {S, Carry_o, Ovf_o}; overflow taken from operand/result signs.
  function automatic logic [N+1:0] model(logic [N-1:0] a, logic [N-1:0] b, logic ci, logic sub);
    logic [N-1:0] be;
    logic         c;
    logic [N:0]   r;
    logic         ov;
    be = sub ? ~b : b;
    c  = sub ? 1'b1 : ci;
    r  = {1'b0, a} + {1'b0, be} + {{N{1'b0}}, c};
    ov = (a[N-1] == be[N-1]) && (r[N-1] != a[N-1]);
    return {r[N-1:0], r[N], ov};
  endfunction

  always @(negedge clk) begin
    logic [N+1:0] exp_v;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        rx_cnt++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got S=%h co=%b ov=%b with nothing pending",
                   bus.S, bus.Carry_o, bus.Ovf_o);
        end else begin
          exp_v = exp_q.pop_front();
          if ({bus.S, bus.Carry_o, bus.Ovf_o} !== exp_v) begin
            fails++;
            $display("FAIL sb_result: got S=%h co=%b ov=%b, expected S=%h co=%b ov=%b",
                     bus.S, bus.Carry_o, bus.Ovf_o, exp_v[N+1:2], exp_v[1], exp_v[0]);
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.A, bus.B, bus.Carry_i, bus.Sub_i));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || bus.out_valid === 1'b1) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.Carry_i   = 1'b0;
    bus.Sub_i     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    tests++; if (bus.S !== 16'h0000) begin fails++; $display("FAIL reset_s: got %h, expected 0000", bus.S); end
    tests++; if (bus.Carry_o !== 1'b0) begin fails++; $display("FAIL reset_carry: got %b, expected 0", bus.Carry_o); end
    tests++; if (bus.Ovf_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b, expected 0", bus.Ovf_o); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  task automatic test_directed();
    vec_t v [6];
    v[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    v[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    v[2] = '{16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    v[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    v[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    v[5] = '{16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b0};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int lat;
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.A        = v[i].a;
      bus.B        = v[i].b;
      bus.Carry_i  = v[i].ci;
      bus.Sub_i    = v[i].sub;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 12) begin
        @(posedge clk); #1;
        lat++;
      end
      tests++; if (lat != 4) begin fails++; $display("FAIL dir%0d_latency: got %0d cycles, expected 4", i, lat); end
      tests++; if (bus.S !== v[i].s) begin fails++; $display("FAIL dir%0d_s: got %h, expected %h", i, bus.S, v[i].s); end
      tests++; if (bus.Carry_o !== v[i].co) begin fails++; $display("FAIL dir%0d_carry: got %b, expected %b", i, bus.Carry_o, v[i].co); end
      tests++; if (bus.Ovf_o !== v[i].ov) begin fails++; $display("FAIL dir%0d_ovf: got %b, expected %b", i, bus.Ovf_o, v[i].ov); end
    end
  endtask

  task automatic test_back_to_back();
    int          sent = 0;
    int          dcyc = 0;
    int          rx0;
    logic [15:0] held;
    drain();
    rx0           = rx_cnt;
    bus.out_ready = 1'b1;
    fork
      begin
        while (sent < 8 && dcyc < 100) begin
          @(posedge clk); #1;
          bus.in_valid = 1'b1;
          bus.A        = 16'(sent);
          bus.B        = 16'(sent) << 8;
          bus.Carry_i  = 1'b0;
          bus.Sub_i    = 1'b0;
          @(negedge clk);
          if (bus.in_ready === 1'b1) sent++;
          dcyc++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
      begin
        int w = 0;
        while (bus.out_valid !== 1'b1 && w < 50) begin
          @(posedge clk); #1;
          w++;
        end
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL stream_first_valid: got %b, expected 1", bus.out_valid); end
        bus.out_ready = 1'b0;
        held = bus.S;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall%0d_in_ready: got %b, expected 0", c, bus.in_ready); end
          tests++; if (bus.S !== held || bus.out_valid !== 1'b1) begin
            fails++; $display("FAIL stall%0d_hold: got S=%h v=%b, expected S=%h v=1", c, bus.S, bus.out_valid, held);
          end
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    tests++; if (rx_cnt - rx0 != 8) begin fails++; $display("FAIL stream_count: got %0d results, expected 8", rx_cnt - rx0); end
    tests++; if (sent != 8) begin fails++; $display("FAIL stream_sent: got %0d accepts, expected 8", sent); end
  endtask

  task automatic test_reset_midflight();
    int w   = 0;
    int lat = 0;
    drain();
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.A        = 16'h1111;
    bus.B        = 16'h2222;
    bus.Carry_i  = 1'b0;
    bus.Sub_i    = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    while (bus.out_valid !== 1'b1 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    tests++; if (bus.out_valid !== 1'b1 || bus.S !== 16'h3333) begin
      fails++; $display("FAIL rst_prefill: got v=%b S=%h, expected v=1 S=3333", bus.out_valid, bus.S);
    end
    rst = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b, expected 0", bus.out_valid); end
    tests++; if (bus.S !== 16'h0000) begin fails++; $display("FAIL rst_async_s: got %h, expected 0000", bus.S); end
    exp_q.delete();
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;

    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.A        = 16'h0101;
    bus.B        = 16'h0202;
    @(posedge clk); #1;
    bus.A        = 16'h0303;
    @(posedge clk); #1;
    bus.A        = 16'h0505;
    rst          = 1'b1;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.S !== 16'h0000) begin
      fails++; $display("FAIL rst_mid: got v=%b S=%h, expected v=0 S=0000", bus.out_valid, bus.S);
    end
    bus.in_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;

    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.A        = 16'h4000;
    bus.B        = 16'h0001;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++; if (lat != 4) begin fails++; $display("FAIL rst_recover_latency: got %0d, expected 4", lat); end
    tests++; if (bus.S !== 16'h4001) begin fails++; $display("FAIL rst_recover_s: got %h, expected 4001", bus.S); end
  endtask

  task automatic test_random();
    int acc = 0;
    int cyc = 0;
    drain();
    while (acc < 10000 && cyc < 60000) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.A         = 16'($urandom);
      bus.B         = 16'($urandom);
      bus.Carry_i   = 1'($urandom_range(0, 1));
      bus.Sub_i     = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) acc++;
      cyc++;
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drain();
    tests++; if (acc != 10000) begin fails++; $display("FAIL random_accepts: got %0d, expected 10000", acc); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL random_pending: got %0d, expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
